// File: rtl/apb3_completer_mem_ws_if.sv
// APB3 completer-side bus bundle for apb3_completer_mem_ws.
// The requester drives address/control/write data; the completer returns data, ready and error.
interface apb3_completer_mem_ws_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic [AddressWidth-1:0] paddr;
    logic                    pwrite;
    logic                    psel;
    logic                    penable;
    logic [DataWidth-1:0]    pwdata;
    logic [DataWidth-1:0]    prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb3_completer_mem_ws.sv
// APB3 completer memory with programmable read/write wait states, PSLVERR on
// misaligned, out-of-range or read-only accesses, and a saturating error counter.
module apb3_completer_mem_ws #(
    parameter int AddressWidth    = 20,
    parameter int DataWidth       = 32,
    parameter int Depth           = 256,
    parameter int ReadWaitStates  = 0,
    parameter int WriteWaitStates = 0,
    parameter int ReadOnlyWords   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    apb3_completer_mem_ws_if.slave        bus,
    output logic [7:0]                    err_count
);

    localparam int unsigned Lsb  = $clog2(DataWidth / 8);
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam longint unsigned MemBytes = longint'(Depth) * longint'(DataWidth / 8);
    localparam logic [AddressWidth-1:0] LsbMask = AddressWidth'((1 << Lsb) - 1);
    localparam int unsigned RoBase = Depth - ReadOnlyWords;
    localparam logic [3:0] RdWait = 4'(ReadWaitStates);
    localparam logic [3:0] WrWait = 4'(WriteWaitStates);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state, next_state;

    logic [DataWidth-1:0] mem [Depth];
    logic [3:0]           cnt;
    logic                 dir;
    logic                 err_q;
    logic [IdxW-1:0]      idx_q;
    logic [DataWidth-1:0] prdata_q;

    logic [IdxW-1:0] idx_c;
    logic            misaligned;
    logic            out_of_range;
    logic            ro_hit;
    logic            err_c;
    logic            load;
    logic            complete;
    logic            abort;
    logic            pready_c;

    // Error classification happens in the setup phase and is registered with the access.
    assign idx_c        = bus.paddr[Lsb +: IdxW];
    assign misaligned   = |(bus.paddr & LsbMask);
    assign out_of_range = 64'(bus.paddr) >= MemBytes;
    assign ro_hit       = bus.pwrite && (32'(idx_c) >= RoBase);
    assign err_c        = misaligned || out_of_range || ro_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        pready_c    = 1'b0;
        load        = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    load       = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                // pready depends only on state and counter; psel only decides abort vs complete.
                pready_c = (cnt == 4'd0);
                if (!bus.psel) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        bus.pready  = pready_c;
        bus.pslverr = pready_c & err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dir       <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            prdata_q  <= '0;
            err_count <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            dir   <= bus.pwrite;
            err_q <= err_c;
            idx_q <= idx_c;
            cnt   <= bus.pwrite ? WrWait : RdWait;
            if (!bus.pwrite) begin
                prdata_q <= err_c ? '0 : mem[idx_c];
            end
        end else if (state == ACCESS) begin
            if (abort) begin
                cnt <= '0;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (complete) begin
                if (dir && !err_q) begin
                    mem[idx_q] <= bus.pwdata;
                end
                if (err_q && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign bus.prdata = prdata_q;

endmodule

// File: tb/tb_apb3_completer_mem_ws.sv
// Scoreboard bench for apb3_completer_mem_ws: three instances with different
// wait-state / read-only configurations share one requester via a select mux.
module tb_apb3_completer_mem_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        rst_c = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [19:0] paddr = '0;
    logic [31:0] pwdata = '0;
    int          sel = 0;

    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  err_count;
    logic [7:0]  ec_a, ec_b, ec_c;

    apb3_completer_mem_ws_if #(.AddressWidth(20), .DataWidth(32)) bus_a ();
    apb3_completer_mem_ws_if #(.AddressWidth(20), .DataWidth(32)) bus_b ();
    apb3_completer_mem_ws_if #(.AddressWidth(20), .DataWidth(32)) bus_c ();

    assign bus_a.psel = psel && (sel == 0);
    assign bus_b.psel = psel && (sel == 1);
    assign bus_c.psel = psel && (sel == 2);
    assign bus_a.penable = penable;  assign bus_b.penable = penable;  assign bus_c.penable = penable;
    assign bus_a.pwrite  = pwrite;   assign bus_b.pwrite  = pwrite;   assign bus_c.pwrite  = pwrite;
    assign bus_a.paddr   = paddr;    assign bus_b.paddr   = paddr;    assign bus_c.paddr   = paddr;
    assign bus_a.pwdata  = pwdata;   assign bus_b.pwdata  = pwdata;   assign bus_c.pwdata  = pwdata;

    always_comb begin
        case (sel)
            1: begin prdata = bus_b.prdata; pready = bus_b.pready; pslverr = bus_b.pslverr; err_count = ec_b; end
            2: begin prdata = bus_c.prdata; pready = bus_c.pready; pslverr = bus_c.pslverr; err_count = ec_c; end
            default: begin prdata = bus_a.prdata; pready = bus_a.pready; pslverr = bus_a.pslverr; err_count = ec_a; end
        endcase
    end

    apb3_completer_mem_ws #(.AddressWidth(20), .DataWidth(32), .Depth(256),
        .ReadWaitStates(0), .WriteWaitStates(0), .ReadOnlyWords(4))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a), .err_count(ec_a));
    apb3_completer_mem_ws #(.AddressWidth(20), .DataWidth(32), .Depth(256),
        .ReadWaitStates(3), .WriteWaitStates(1), .ReadOnlyWords(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b), .err_count(ec_b));
    apb3_completer_mem_ws #(.AddressWidth(20), .DataWidth(32), .Depth(256),
        .ReadWaitStates(0), .WriteWaitStates(5), .ReadOnlyWords(0))
        dut_c (.clk(clk), .rst(rst_c), .bus(bus_c), .err_count(ec_c));

    // Reference model per instance
    int          rws [3] = '{0, 3, 0};
    int          wws [3] = '{0, 1, 5};
    int          row [3] = '{4, 0, 0};
    logic [31:0] mdl_mem [3][256];
    int          mdl_ec [3];

    typedef struct {
        string       name;
        bit          is_read;
        logic [31:0] data;
        bit          err;
        int          cycles;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Full APB transfer on the selected instance; starts and ends at posedge+1.
    task automatic xfer(input bit wr, input logic [19:0] addr, input logic [31:0] data, input string name);
        exp_t        e;
        int          idx;
        bit          err;
        bit          done;
        int          cyc;
        logic [31:0] r_data;
        logic        r_err;
        idx = int'(addr[9:2]);
        err = (addr[1:0] != 2'b00) || (addr >= 20'h400) || (wr && idx >= 256 - row[sel]);
        e.name    = name;
        e.is_read = !wr;
        e.err     = err;
        e.cycles  = 2 + (wr ? wws[sel] : rws[sel]);
        e.data    = err ? 32'h0 : mdl_mem[sel][idx];
        sb.push_back(e);

        total++;
        if (pready !== 1'b0) begin
            bad++;
            $display("FAIL %s setup_pready: got %b want 0", name, pready);
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        cyc = 1;
        done = 1'b0;
        r_data = '0;
        r_err = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc++;
            if (pready === 1'b1) begin
                done   = 1'b1;
                r_data = prdata;
                r_err  = pslverr;
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;

        e = sb.pop_front();
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: no pready within 40 cycles", e.name);
        end else begin
            if (cyc !== e.cycles) begin
                bad++;
                $display("FAIL %s cycles: got %0d want %0d", e.name, cyc, e.cycles);
            end
            total++;
            if (r_err !== e.err) begin
                bad++;
                $display("FAIL %s pslverr: got %b want %b", e.name, r_err, e.err);
            end
            if (e.is_read) begin
                total++;
                if (r_data !== e.data) begin
                    bad++;
                    $display("FAIL %s prdata: got %h want %h", e.name, r_data, e.data);
                end
            end
        end
        if (wr && !err) mdl_mem[sel][idx] = data;
        if (err && mdl_ec[sel] < 255) mdl_ec[sel]++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_c = 1'b1;
        for (int s = 0; s < 3; s++) begin
            mdl_ec[s] = 0;
            for (int i = 0; i < 256; i++) mdl_mem[s][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            total++;
            if ({pready, pslverr, prdata, err_count} !== 42'h0) begin
                bad++;
                $display("FAIL reset_%0d: got pready=%b pslverr=%b prdata=%h err_count=%0d want all 0",
                         s, pready, pslverr, prdata, err_count);
            end
        end
        rst = 1'b0; rst_c = 1'b0;
        sel = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        sel = 0;
        xfer(1'b1, 20'h10, 32'hDEADBEEF, "basic_wr");
        xfer(1'b0, 20'h10, 32'h0, "basic_rd");
    endtask

    task automatic test_wait_states();
        sel = 1;
        xfer(1'b1, 20'h4, 32'h1234_5678, "ws_wr");
        xfer(1'b0, 20'h4, 32'h0, "ws_rd");
        sel = 0;
    endtask

    task automatic test_errors();
        sel = 0;
        xfer(1'b0, 20'h400, 32'h0, "err_rd_oor");
        xfer(1'b0, 20'h002, 32'h0, "err_rd_misaligned");
        total++;
        if (err_count !== 8'(mdl_ec[0])) begin
            bad++;
            $display("FAIL err_count_2: got %0d want %0d", err_count, mdl_ec[0]);
        end
        xfer(1'b1, 20'h400, 32'hFFFF_FFFF, "err_wr_oor");
        xfer(1'b0, 20'h000, 32'h0, "err_alias_unchanged");
    endtask

    task automatic test_read_only();
        sel = 0;
        xfer(1'b1, 20'h3FC, 32'h55, "ro_wr_top");
        xfer(1'b0, 20'h3FC, 32'h0, "ro_rd_top");
        xfer(1'b1, 20'h3F8, 32'hAA, "ro_wr_254");
        xfer(1'b1, 20'h3EC, 32'h0BAD_F00D, "ro_wr_251");
        xfer(1'b0, 20'h3EC, 32'h0, "ro_rd_251");
    endtask

    task automatic test_protocol();
        sel = 0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 20'h2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (pready !== 1'b0) begin
                bad++;
                $display("FAIL protocol_pready: got %b want 0", pready);
            end
        end
        psel = 1'b0; penable = 1'b0;
        total++;
        if (err_count !== 8'(mdl_ec[0])) begin
            bad++;
            $display("FAIL protocol_err_count: got %0d want %0d", err_count, mdl_ec[0]);
        end
        xfer(1'b0, 20'h10, 32'h0, "protocol_recover");
    endtask

    task automatic test_back_to_back();
        logic [19:0] addrs [8];
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            addrs[i] = {10'h0, 8'($urandom_range(0, 240)), 2'b00};
            xfer(1'b1, addrs[i], $urandom, "b2b_wr");
        end
        for (int i = 0; i < 8; i++) xfer(1'b0, addrs[i], 32'h0, "b2b_rd");
    endtask

    task automatic test_abort();
        sel = 1;
        xfer(1'b1, 20'h8, 32'h1111_1111, "abort_pre_wr");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h8; pwdata = 32'h2222_2222;
        @(posedge clk); #1;
        penable = 1'b1;
        total++;
        if (pready !== 1'b0) begin
            bad++;
            $display("FAIL abort_wait_pready: got %b want 0", pready);
        end
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (pready !== 1'b0) begin
                bad++;
                $display("FAIL abort_idle_pready: got %b want 0", pready);
            end
        end
        xfer(1'b0, 20'h8, 32'h0, "abort_rd_unchanged");
        total++;
        if (err_count !== 8'(mdl_ec[1])) begin
            bad++;
            $display("FAIL abort_err_count: got %0d want %0d", err_count, mdl_ec[1]);
        end
        sel = 0;
    endtask

    task automatic test_reset_mid();
        sel = 2;
        xfer(1'b0, 20'h2, 32'h0, "rstmid_err");
        xfer(1'b1, 20'h20, 32'hA5A5_A5A5, "rstmid_wr");
        xfer(1'b0, 20'h20, 32'h0, "rstmid_rd");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h20; pwdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_c = 1'b1;
        #1;
        total++;
        if ({pready, pslverr, prdata, err_count} !== 42'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got pready=%b pslverr=%b prdata=%h err_count=%0d want all 0",
                     pready, pslverr, prdata, err_count);
        end
        mdl_ec[2] = 0;
        for (int i = 0; i < 256; i++) mdl_mem[2][i] = '0;
        @(posedge clk); #1;
        rst_c = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 20'h20, 32'h0, "rstmid_rd_cleared");
        sel = 0;
    endtask

    task automatic test_saturation();
        sel = 0;
        for (int i = 0; i < 260; i++) xfer(1'b0, 20'h2, 32'h0, "sat_err");
        total++;
        if (err_count !== 8'(mdl_ec[0]) || mdl_ec[0] != 255) begin
            bad++;
            $display("FAIL sat_err_count: got %0d want 255", err_count);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_wait_states();
        test_errors();
        test_read_only();
        test_protocol();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1ms");
        $fatal(1, "watchdog");
    end

endmodule
